// File: rtl/approx_mult_ctrl.sv
// Sequencing FSM for the approximate-multiplier datapath: load pair, normalise, multiply, shift, write.
// Define APPROX_CTRL_PAUSE_EN to add a pause input that freezes the run in place.
module approx_mult_ctrl #(
  parameter int unsigned PAIRS      = 8,
  parameter int unsigned NORM_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef APPROX_CTRL_PAUSE_EN
  input  logic pause,
`endif
  input  logic lsb_cnt,
  input  logic co_cntr_ld,
  input  logic end_shift1,
  input  logic end_shift2,
  input  logic co_cnt_sh,
  output logic cntr_ld_init,
  output logic cntr_ld_en,
  output logic cntr_sh1_init,
  output logic cntr_sh2_init,
  output logic cntr_sh1_en,
  output logic cntr_sh2_en,
  output logic cntr_sh_ld,
  output logic cntr_sh_en,
  output logic en_sh_16bit,
  output logic sh_result_ld,
  output logic sh_result_shift,
  output logic wr_out_ram,
  output logic busy,
  output logic done
);

  localparam int unsigned PairW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int unsigned WdW   = (NORM_LIMIT > 1) ? $clog2(NORM_LIMIT) : 1;
  localparam logic [PairW-1:0] PairLast = PairW'(PAIRS - 1);
  localparam logic [WdW-1:0]   WdLast   = WdW'(NORM_LIMIT - 1);

  typedef enum logic [3:0] {
    StIdle, StInit, StLoadA, StLoadB, StNorm, StMult, StShift, StWrite, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [PairW-1:0] pair_q, pair_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             stall;

  logic ld_init_q, ld_en_q, sh_init_q, sh_ld_q, wr_q, busy_q, done_q;

  // The datapath steers words by lsb_cnt on its own.
  logic unused_lsb_cnt;
  assign unused_lsb_cnt = lsb_cnt;

`ifdef APPROX_CTRL_PAUSE_EN
  assign stall = pause && (state_q != StIdle) && (state_q != StDone);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    wd_d    = wd_q;
    if (!stall) begin
      unique case (state_q)
        StIdle:  if (start) state_d = StInit;
        StInit: begin
          pair_d  = '0;
          wd_d    = '0;
          state_d = StLoadA;
        end
        StLoadA: state_d = StLoadB;
        StLoadB: begin
          wd_d    = '0;
          state_d = StNorm;
        end
        StNorm: begin
          // Watchdog caps normalisation so a stuck status pin cannot hang the run.
          if ((!end_shift1 && !end_shift2) || (wd_q == WdLast)) begin
            state_d = StMult;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        StMult:  state_d = StShift;
        StShift: if (co_cnt_sh) state_d = StWrite;
        StWrite: begin
          if ((pair_q == PairLast) || co_cntr_ld) begin
            state_d = StDone;
          end else begin
            pair_d  = pair_q + 1'b1;
            state_d = StLoadA;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pair_q    <= '0;
      wd_q      <= '0;
      ld_init_q <= 1'b0;
      ld_en_q   <= 1'b0;
      sh_init_q <= 1'b0;
      sh_ld_q   <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      wd_q      <= wd_d;
      ld_init_q <= (state_d == StInit);
      ld_en_q   <= (state_d == StLoadA) || (state_d == StLoadB);
      sh_init_q <= (state_d == StLoadB);
      sh_ld_q   <= (state_d == StMult);
      wr_q      <= (state_d == StWrite);
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
    end
  end

  assign cntr_ld_init    = ld_init_q & ~stall;
  assign cntr_ld_en      = ld_en_q & ~stall;
  assign en_sh_16bit     = ld_en_q & ~stall;
  assign cntr_sh1_init   = sh_init_q & ~stall;
  assign cntr_sh2_init   = sh_init_q & ~stall;
  assign cntr_sh_ld      = sh_ld_q & ~stall;
  assign sh_result_ld    = sh_ld_q & ~stall;
  assign wr_out_ram      = wr_q & ~stall;
  assign cntr_sh1_en     = (state_q == StNorm) & end_shift1 & ~stall;
  assign cntr_sh2_en     = (state_q == StNorm) & end_shift2 & ~stall;
  assign sh_result_shift = (state_q == StShift) & ~co_cnt_sh & ~stall;
  assign cntr_sh_en      = (state_q == StShift) & ~co_cnt_sh & ~stall;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_approx_mult_ctrl.sv
// Self-checking bench for approx_mult_ctrl: a per-pair phase model expands into an expected
// cycle timeline that also supplies the datapath status inputs.
module tb_approx_mult_ctrl;

  localparam int P = 3;
  localparam int L = 8;

  localparam int B_LD_INIT = 0, B_LD_EN = 1, B_SH1_INIT = 2, B_SH2_INIT = 3, B_SH1_EN = 4;
  localparam int B_SH2_EN = 5, B_SH_LD = 6, B_SH_EN = 7, B_EN16 = 8, B_RES_LD = 9;
  localparam int B_RES_SH = 10, B_WR = 11, B_BUSY = 12, B_DONE = 13;

  typedef struct packed {
    logic        pause;
    logic        lsb;
    logic        co_ld;
    logic        e1;
    logic        e2;
    logic        co_sh;
    logic [13:0] exp;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic lsb_cnt = 1'b0, co_cntr_ld = 1'b0, end_shift1 = 1'b0, end_shift2 = 1'b0;
  logic co_cnt_sh = 1'b0;
`ifdef APPROX_CTRL_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic cntr_ld_init, cntr_ld_en, cntr_sh1_init, cntr_sh2_init, cntr_sh1_en, cntr_sh2_en;
  logic cntr_sh_ld, cntr_sh_en, en_sh_16bit, sh_result_ld, sh_result_shift, wr_out_ram;
  logic busy, done;
  logic [13:0] obs;

  int n_checks = 0;
  int n_errors = 0;
  int k1_a[P], k2_a[P], s_a[P];
  cyc_t tl[$];
  int cnt_wr, cnt_busy, cnt_sh1, cnt_sh2, cnt_shift, done_idx;

  approx_mult_ctrl #(.PAIRS(P), .NORM_LIMIT(L)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef APPROX_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .lsb_cnt(lsb_cnt), .co_cntr_ld(co_cntr_ld), .end_shift1(end_shift1),
    .end_shift2(end_shift2), .co_cnt_sh(co_cnt_sh),
    .cntr_ld_init(cntr_ld_init), .cntr_ld_en(cntr_ld_en), .cntr_sh1_init(cntr_sh1_init),
    .cntr_sh2_init(cntr_sh2_init), .cntr_sh1_en(cntr_sh1_en), .cntr_sh2_en(cntr_sh2_en),
    .cntr_sh_ld(cntr_sh_ld), .cntr_sh_en(cntr_sh_en), .en_sh_16bit(en_sh_16bit),
    .sh_result_ld(sh_result_ld), .sh_result_shift(sh_result_shift), .wr_out_ram(wr_out_ram),
    .busy(busy), .done(done)
  );

  assign obs = {done, busy, wr_out_ram, sh_result_shift, sh_result_ld, en_sh_16bit, cntr_sh_en,
                cntr_sh_ld, cntr_sh2_en, cntr_sh1_en, cntr_sh2_init, cntr_sh1_init, cntr_ld_en,
                cntr_ld_init};

  always #5 clk = ~clk;

  function automatic logic [13:0] bv(input int b);
    bv = 14'd1 << b;
  endfunction

  function automatic cyc_t rnd_cyc();
    cyc_t c;
    c.pause = 1'b0;
    c.lsb   = 1'($urandom);
    c.co_ld = 1'($urandom);
    c.e1    = 1'($urandom);
    c.e2    = 1'($urandom);
    c.co_sh = 1'($urandom);
    c.exp   = '0;
    return c;
  endfunction

  task automatic set_defaults();
    for (int p = 0; p < P; p++) begin
      k1_a[p] = 0;
      k2_a[p] = 0;
      s_a[p]  = 0;
    end
  endtask

  // Expected timeline from INIT to DONE; status inputs not under test are random noise.
  task automatic build_run(input int stop);
    cyc_t c;
    int n;
    tl.delete();
    c = rnd_cyc(); c.exp = bv(B_BUSY) | bv(B_LD_INIT); tl.push_back(c);
    for (int p = 0; p < P; p++) begin
      c = rnd_cyc(); c.exp = bv(B_BUSY) | bv(B_EN16) | bv(B_LD_EN); tl.push_back(c);
      c = rnd_cyc();
      c.exp = bv(B_BUSY) | bv(B_EN16) | bv(B_LD_EN) | bv(B_SH1_INIT) | bv(B_SH2_INIT);
      tl.push_back(c);
      n = ((k1_a[p] > k2_a[p]) ? k1_a[p] : k2_a[p]) + 1;
      if (n > L) n = L;
      for (int j = 0; j < n; j++) begin
        c = rnd_cyc();
        c.e1 = (j < k1_a[p]);
        c.e2 = (j < k2_a[p]);
        c.exp = bv(B_BUSY) | (c.e1 ? bv(B_SH1_EN) : 14'd0) | (c.e2 ? bv(B_SH2_EN) : 14'd0);
        tl.push_back(c);
      end
      c = rnd_cyc(); c.exp = bv(B_BUSY) | bv(B_RES_LD) | bv(B_SH_LD); tl.push_back(c);
      for (int j = 0; j <= s_a[p]; j++) begin
        c = rnd_cyc();
        c.co_sh = (j == s_a[p]);
        c.exp = bv(B_BUSY) | ((j < s_a[p]) ? (bv(B_RES_SH) | bv(B_SH_EN)) : 14'd0);
        tl.push_back(c);
      end
      c = rnd_cyc(); c.co_ld = (p == stop); c.exp = bv(B_BUSY) | bv(B_WR); tl.push_back(c);
      if (p == stop) break;
    end
    c = rnd_cyc(); c.exp = bv(B_BUSY) | bv(B_DONE); tl.push_back(c);
  endtask

`ifdef APPROX_CTRL_PAUSE_EN
  task automatic insert_pause(input int at, input int len);
    cyc_t c;
    cyc_t nq[$];
    for (int i = 0; i < tl.size(); i++) begin
      if (i == at) begin
        for (int j = 0; j < len; j++) begin
          c = rnd_cyc(); c.pause = 1'b1; c.exp = bv(B_BUSY); nq.push_back(c);
        end
      end
      nq.push_back(tl[i]);
    end
    tl = nq;
  endtask
`endif

  function automatic int first_shift_idx();
    for (int i = 0; i < tl.size(); i++) if (tl[i].exp[B_RES_SH]) return i;
    return -1;
  endfunction

  // Starts in IDLE just after a rising edge; replays tl and compares every cycle.
  task automatic drive_run(input bit chain, input int abort_at, input string name);
    cnt_wr = 0; cnt_busy = 0; cnt_sh1 = 0; cnt_sh2 = 0; cnt_shift = 0; done_idx = -1;
    start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'd0) begin
      n_errors++;
      $display("FAIL %s idle: got %b expected %b", name, obs, 14'd0);
    end
    for (int i = 0; i < tl.size(); i++) begin
      @(posedge clk); #1;
      lsb_cnt    = tl[i].lsb;
      co_cntr_ld = tl[i].co_ld;
      end_shift1 = tl[i].e1;
      end_shift2 = tl[i].e2;
      co_cnt_sh  = tl[i].co_sh;
`ifdef APPROX_CTRL_PAUSE_EN
      pause = tl[i].pause;
`endif
      start = (i == tl.size() - 1) ? chain : 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (obs !== tl[i].exp) begin
        n_errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, i, obs, tl[i].exp);
      end
      if (wr_out_ram) cnt_wr++;
      if (busy) cnt_busy++;
      if (cntr_sh1_en) cnt_sh1++;
      if (cntr_sh2_en) cnt_sh2++;
      if (sh_result_shift) cnt_shift++;
      if (done) done_idx = i;
      if (i == abort_at) return;
    end
    @(posedge clk); #1;
`ifdef APPROX_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 14'd0) begin
      n_errors++;
      $display("FAIL reset_hold: got %b expected %b", obs, 14'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'd0) begin
      n_errors++;
      $display("FAIL reset_release: got %b expected %b", obs, 14'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    set_defaults(); build_run(-1); drive_run(1'b0, -1, "basic");
    n_checks++;
    if (cnt_wr !== P) begin
      n_errors++; $display("FAIL basic_writes: got %0d expected %0d", cnt_wr, P);
    end
    n_checks++;
    if (cnt_busy !== 6 * P + 2) begin
      n_errors++; $display("FAIL basic_busy: got %0d expected %0d", cnt_busy, 6 * P + 2);
    end
    n_checks++;
    if (done_idx !== 6 * P + 1) begin
      n_errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_idx, 6 * P + 1);
    end
  endtask

  task automatic test_norm();
    set_defaults(); k1_a[0] = 3; k2_a[0] = 5; build_run(-1); drive_run(1'b0, -1, "norm");
    n_checks++;
    if (cnt_sh1 !== 3 || cnt_sh2 !== 5) begin
      n_errors++; $display("FAIL norm_pulses: got %0d/%0d expected 3/5", cnt_sh1, cnt_sh2);
    end
    n_checks++;
    if (cnt_busy !== 2 + 11 + 6 * (P - 1)) begin
      n_errors++; $display("FAIL norm_busy: got %0d expected %0d", cnt_busy, 13 + 6 * (P - 1));
    end
  endtask

  task automatic test_watchdog();
    set_defaults(); k1_a[0] = 100; build_run(-1); drive_run(1'b0, -1, "watchdog");
    n_checks++;
    if (cnt_sh1 !== L) begin
      n_errors++; $display("FAIL watchdog_pulses: got %0d expected %0d", cnt_sh1, L);
    end
    n_checks++;
    if (cnt_busy !== 2 + 5 + L + 6 * (P - 1)) begin
      n_errors++;
      $display("FAIL watchdog_busy: got %0d expected %0d", cnt_busy, 7 + L + 6 * (P - 1));
    end
  endtask

  task automatic test_shift();
    set_defaults(); s_a[0] = 4; build_run(-1); drive_run(1'b0, -1, "shift");
    n_checks++;
    if (cnt_shift !== 4) begin
      n_errors++; $display("FAIL shift_pulses: got %0d expected 4", cnt_shift);
    end
    n_checks++;
    if (cnt_busy !== 2 + 10 + 6 * (P - 1)) begin
      n_errors++; $display("FAIL shift_busy: got %0d expected %0d", cnt_busy, 12 + 6 * (P - 1));
    end
  endtask

  task automatic test_early_stop();
    set_defaults(); build_run(0); drive_run(1'b0, -1, "early_stop");
    n_checks++;
    if (cnt_wr !== 1 || done_idx !== 7) begin
      n_errors++;
      $display("FAIL early_stop: got writes %0d done@%0d expected 1 done@7", cnt_wr, done_idx);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      set_defaults(); k2_a[r % P] = 2; build_run(-1); drive_run(1'b1, -1, "back_to_back");
      n_checks++;
      if (cnt_wr !== P) begin
        n_errors++; $display("FAIL back_to_back_writes: got %0d expected %0d", cnt_wr, P);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int at;
    set_defaults(); s_a[0] = 4; build_run(-1);
    at = first_shift_idx() + 1;
    drive_run(1'b0, at, "mid_shift");
    #1 rst = 1'b0; start = 1'b0;
    #1;
    n_checks++;
    if (obs !== 14'd0) begin
      n_errors++; $display("FAIL mid_shift_reset: got %b expected %b", obs, 14'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'd0) begin
      n_errors++; $display("FAIL mid_shift_idle: got %b expected %b", obs, 14'd0);
    end
    @(posedge clk); #1;
    set_defaults(); build_run(-1); drive_run(1'b0, -1, "after_reset");
    n_checks++;
    if (cnt_wr !== P) begin
      n_errors++; $display("FAIL after_reset_writes: got %0d expected %0d", cnt_wr, P);
    end
  endtask

`ifdef APPROX_CTRL_PAUSE_EN
  task automatic test_pause();
    set_defaults(); s_a[0] = 4; build_run(-1);
    insert_pause(first_shift_idx() + 2, 3);
    drive_run(1'b0, -1, "pause");
    n_checks++;
    if (cnt_shift !== 4) begin
      n_errors++; $display("FAIL pause_shifts: got %0d expected 4", cnt_shift);
    end
    n_checks++;
    if (cnt_busy !== 2 + 10 + 6 * (P - 1) + 3) begin
      n_errors++; $display("FAIL pause_busy: got %0d expected %0d", cnt_busy, 15 + 6 * (P - 1));
    end
  endtask
`endif

  task automatic test_random();
    int stop;
    int exp_wr;
    for (int r = 0; r < 20; r++) begin
      for (int p = 0; p < P; p++) begin
        k1_a[p] = int'($urandom_range(0, 10));
        k2_a[p] = int'($urandom_range(0, 10));
        s_a[p]  = int'($urandom_range(0, 5));
      end
      stop = int'($urandom_range(0, P)) - 1;
      build_run(stop);
`ifdef APPROX_CTRL_PAUSE_EN
      if ($urandom_range(0, 1) == 1)
        insert_pause(int'($urandom_range(0, tl.size() - 2)), int'($urandom_range(1, 3)));
`endif
      drive_run(1'(r % 2), -1, "random");
      exp_wr = (stop >= 0) ? stop + 1 : P;
      n_checks++;
      if (cnt_wr !== exp_wr) begin
        n_errors++; $display("FAIL random_writes: got %0d expected %0d", cnt_wr, exp_wr);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_norm();
    test_watchdog();
    test_shift();
    test_early_stop();
    test_back_to_back();
    test_reset_mid_shift();
`ifdef APPROX_CTRL_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
